// File: rtl/microprocessor_poller_pkg.sv
// Shared definitions for the switch poller: FSM encoding and PIO register map.
package microprocessor_poller_pkg;

  // Poll sequencer states. WAIT counts out the period, READ issues the strobe,
  // SAMPLE consumes the slave's fixed-latency read data.
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    READ   = 2'd1,
    SAMPLE = 2'd2
  } poll_state_t;

  // Data register offset of the switch PIO slave.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/microprocessor_switches_debounce.sv
// Debounce stage: tracks the most recent sample value and how many consecutive
// polls it has been seen, and promotes it to switches_out once it is stable.
module microprocessor_switches_debounce
  import microprocessor_poller_pkg::*;
#(
  parameter int WIDTH        = 9,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] switches_out,
  output logic             accept,
  output logic [WIDTH-1:0] rise_mask
);

  localparam int CNT_W = $clog2(STABLE_COUNT + 1);

  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] candidate_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Next candidate/count for this poll; acceptance looks at the updated count
  // so a value is promoted on the same edge its STABLE_COUNT-th sample lands.
  always_comb begin
    candidate_next = candidate;
    cnt_next       = cnt;
    if (sample_en) begin
      if (sample != candidate) begin
        candidate_next = sample;
        cnt_next       = CNT_W'(1);
      end else if (cnt != CNT_W'(STABLE_COUNT)) begin
        cnt_next = cnt + 1'b1;
      end
    end
    accept    = sample_en && (cnt_next == CNT_W'(STABLE_COUNT)) &&
                (candidate_next != switches_out);
    rise_mask = accept ? (candidate_next & ~switches_out) : '0;
  end

  // Debounce state registers; switches_out only moves on an accepted value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate    <= '0;
      cnt          <= '0;
      switches_out <= '0;
    end else begin
      candidate <= candidate_next;
      cnt       <= cnt_next;
      if (accept) begin
        switches_out <= candidate_next;
      end
    end
  end

endmodule

// File: rtl/microprocessor_switches_poller.sv
// Avalon-MM master that periodically reads the switch PIO data register,
// debounces the low WIDTH bits and exposes stable/changed/capture/irq outputs.
//
// Read handshake: avm_read is a registered one-cycle strobe with no
// waitrequest; the slave returns avm_readdata exactly one cycle later, which
// the FSM consumes in SAMPLE. avm_address is tied to the data register.
module microprocessor_switches_poller
  import microprocessor_poller_pkg::*;
#(
  parameter int WIDTH        = 9,
  parameter int POLL_PERIOD  = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  input  logic [WIDTH-1:0] clear_capture,
  output logic [WIDTH-1:0] switches_out,
  output logic             changed,
  output logic [WIDTH-1:0] rise_capture,
  output logic             irq,
  output logic [1:0]       debug_state
);

  localparam int PCNT_W = $clog2(POLL_PERIOD);

  poll_state_t       state;
  poll_state_t       state_next;
  logic [PCNT_W-1:0] period_cnt;
  logic              accept;
  logic [WIDTH-1:0]  rise_mask;
  logic              unused_readdata;

  assign avm_address     = PIO_DATA_ADDR;
  assign irq             = |rise_capture;
  assign debug_state     = state;
  assign unused_readdata = ^avm_readdata[31:WIDTH];

  // Sequencer: WAIT spans POLL_PERIOD-2 cycles so strobes are POLL_PERIOD apart.
  always_comb begin
    state_next = state;
    unique case (state)
      WAIT:    if (period_cnt == PCNT_W'(POLL_PERIOD - 3)) state_next = READ;
      READ:    state_next = SAMPLE;
      SAMPLE:  state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  // State, period counter and registered read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT;
      period_cnt <= '0;
      avm_read   <= 1'b0;
    end else begin
      state    <= state_next;
      avm_read <= (state_next == READ);
      if (state == SAMPLE) begin
        period_cnt <= '0;
      end else if (state == WAIT) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

  microprocessor_switches_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_en    (state == SAMPLE),
    .sample       (avm_readdata[WIDTH-1:0]),
    .switches_out (switches_out),
    .accept       (accept),
    .rise_mask    (rise_mask)
  );

  // Change pulse and sticky rise capture; a new rise beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed      <= 1'b0;
      rise_capture <= '0;
    end else begin
      changed      <= accept;
      rise_capture <= (rise_capture & ~clear_capture) | rise_mask;
    end
  end

endmodule

// File: tb/tb_microprocessor_switches_poller.sv
// Directed bench for microprocessor_switches_poller with POLL_PERIOD=4,
// STABLE_COUNT=3, WIDTH=9. Cycle N = the cycle closed by the N-th rising edge
// after reset release (cycle 0 is observed right after release).
module tb_microprocessor_switches_poller;

  localparam int W = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic [31:0]   avm_readdata = '0;
  logic [W-1:0]  clear_capture = '0;
  logic [W-1:0]  switches_out;
  logic          changed;
  logic [W-1:0]  rise_capture;
  logic          irq;
  logic [1:0]    debug_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int ch_count = 0;

  typedef struct {
    logic [31:0]  rd;
    logic [W-1:0] clr;
    logic         exp_read;
    logic [W-1:0] exp_sw;
    logic         exp_ch;
    logic [W-1:0] exp_rise;
    logic         exp_irq;
  } vec_t;

  vec_t vecs[17];

  microprocessor_switches_poller #(
    .WIDTH        (W),
    .POLL_PERIOD  (4),
    .STABLE_COUNT (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avm_address   (avm_address),
    .avm_read      (avm_read),
    .avm_readdata  (avm_readdata),
    .clear_capture (clear_capture),
    .switches_out  (switches_out),
    .changed       (changed),
    .rise_capture  (rise_capture),
    .irq           (irq),
    .debug_state   (debug_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    cyc      = 0;
    ch_count = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (changed) ch_count++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    // Clean change table: readdata=0x1A5 from cycle 0, with clears interleaved.
    vecs[0]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[1]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[2]  = '{32'h1A5, 9'h000, 1'b1, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[3]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[4]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[5]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[6]  = '{32'h1A5, 9'h000, 1'b1, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[7]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[8]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[9]  = '{32'h1A5, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[10] = '{32'h1A5, 9'h000, 1'b1, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[11] = '{32'h1A5, 9'h1A5, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0};
    vecs[12] = '{32'h1A5, 9'h000, 1'b0, 9'h1A5, 1'b1, 9'h1A5, 1'b1};
    vecs[13] = '{32'h1A5, 9'h004, 1'b0, 9'h1A5, 1'b0, 9'h1A5, 1'b1};
    vecs[14] = '{32'h1A5, 9'h1A1, 1'b1, 9'h1A5, 1'b0, 9'h1A1, 1'b1};
    vecs[15] = '{32'h1A5, 9'h000, 1'b0, 9'h1A5, 1'b0, 9'h000, 1'b0};
    vecs[16] = '{32'h1A5, 9'h000, 1'b0, 9'h1A5, 1'b0, 9'h000, 1'b0};

    // Reset and period: readdata held at 0.
    avm_readdata  = '0;
    clear_capture = '0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      logic [1:0] exp_st;
      exp_st = (c % 4 == 2) ? 2'd1 : ((c % 4 == 3) ? 2'd2 : 2'd0);
      check("period_read", avm_read, (c % 4 == 2));
      check("period_state", debug_state, exp_st);
      check("period_addr", avm_address, 0);
      if (c == 0 || c == 15) begin
        check("period_sw", switches_out, 0);
        check("period_rise", rise_capture, 0);
        check("period_irq", irq, 0);
      end
      step();
    end
    check("period_changed_count", ch_count, 0);

    // Clean change, table-driven.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      avm_readdata  = vecs[i].rd;
      clear_capture = vecs[i].clr;
      check("tbl_read", avm_read, vecs[i].exp_read);
      check("tbl_sw", switches_out, vecs[i].exp_sw);
      check("tbl_changed", changed, vecs[i].exp_ch);
      check("tbl_rise", rise_capture, vecs[i].exp_rise);
      check("tbl_irq", irq, vecs[i].exp_irq);
      step();
    end
    clear_capture = '0;

    // Bounce on bit0: polls see 1,0,1,1,1; accept only after the 5th.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      logic [4:0] seq;
      seq = 5'b11101;
      avm_readdata = {31'd0, seq[p]};
      for (int k = 0; k < 4; k++) begin
        check("bounce_hold_sw", switches_out, 0);
        step();
      end
    end
    check("bounce_sw", switches_out, 9'h001);
    check("bounce_changed", changed, 1);
    check("bounce_rise", rise_capture, 9'h001);
    check("bounce_irq", irq, 1);

    // Clear versus set: bit1 accepted at SAMPLE of cycle 31 while bit0 is cleared.
    avm_readdata = 32'h003;
    step_to(31);
    check("cs_sw_before", switches_out, 9'h001);
    clear_capture = 9'h001;
    step();
    check("cs_sw", switches_out, 9'h003);
    check("cs_changed", changed, 1);
    check("cs_rise", rise_capture, 9'h002);
    check("cs_irq", irq, 1);
    clear_capture = 9'h002;
    step();
    check("cs_rise_cleared", rise_capture, 0);
    check("cs_irq_cleared", irq, 0);
    check("cs_changed_done", changed, 0);
    clear_capture = '0;
    step_to(40);
    check("cs_pulse_count", ch_count, 2);

    // Mid-read reset: strobe drops with no clock edge, period restarts.
    avm_readdata = '0;
    do_reset();
    step_to(2);
    check("mr_read_high", avm_read, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_read_async_drop", avm_read, 0);
    check("mr_state", debug_state, 0);
    check("mr_sw", switches_out, 0);
    do_reset();
    check("mr_c0", avm_read, 0);
    step();
    check("mr_c1", avm_read, 0);
    step();
    check("mr_c2", avm_read, 1);
    step();
    check("mr_c3", avm_read, 0);

    // Upper readdata bits ignored.
    avm_readdata = 32'hFFFF_FE00;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      check("upper_sw", switches_out, 0);
      step();
    end
    check("upper_changed_count", ch_count, 0);
    check("upper_irq", irq, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
